// File: rtl/ps2_mouse_master_ctrl.sv
// PS/2 mouse host: reset/wheel-detect/rate/enable init sequence, then 3/4-byte packet assembly.
// Packet outputs and interrupt appear two cycles after the last byte; no backpressure (mouse cannot be stalled).
module ps2_mouse_master_ctrl #(
  parameter int unsigned INIT_WAIT_CYCLES    = 5_000_000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter bit          ENABLE_WHEEL        = 1'b1,
  parameter logic [7:0]  SAMPLE_RATE         = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       WHEEL_PRESENT,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic       INIT_FAIL,
  output logic [3:0] CURR_STATE
);

  localparam int unsigned CNT_MAX = (INIT_WAIT_CYCLES > RESP_TIMEOUT_CYCLES) ?
                                    INIT_WAIT_CYCLES : RESP_TIMEOUT_CYCLES;
  localparam int          CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INIT_LIM = CW'(INIT_WAIT_CYCLES);
  localparam logic [CW-1:0] RESP_LIM = CW'(RESP_TIMEOUT_CYCLES);
  localparam logic [3:0]  LAST_STEP = ENABLE_WHEEL ? 4'd10 : 4'd3;
  localparam logic [4:0]  RETRY_LIM = 5'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'h0,
    S_SEND      = 4'h1,
    S_WAIT_SENT = 4'h2,
    S_WAIT_RESP = 4'h3,
    S_B0        = 4'h4,
    S_B1        = 4'h5,
    S_B2        = 4'h6,
    S_B3        = 4'h7,
    S_EMIT      = 4'h8,
    S_FAULT     = 4'h9
  } state_t;

  // Full-sequence ROM index; without the wheel probe, steps 1..3 map onto the rate/enable tail.
  function automatic logic [3:0] rom_idx(input logic [3:0] step_i);
    if (ENABLE_WHEEL || step_i == 4'd0) rom_idx = step_i;
    else                                rom_idx = step_i + 4'd7;
  endfunction

  function automatic logic [7:0] rom_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_cmd = 8'hFF;
      4'd1:    rom_cmd = 8'hF3;
      4'd2:    rom_cmd = 8'hC8;
      4'd3:    rom_cmd = 8'hF3;
      4'd4:    rom_cmd = 8'h64;
      4'd5:    rom_cmd = 8'hF3;
      4'd6:    rom_cmd = 8'h50;
      4'd7:    rom_cmd = 8'hF2;
      4'd8:    rom_cmd = 8'hF3;
      4'd9:    rom_cmd = SAMPLE_RATE;
      4'd10:   rom_cmd = 8'hF4;
      default: rom_cmd = 8'hFF;
    endcase
  endfunction

  function automatic logic [1:0] rom_nresp(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_nresp = 2'd3;
      4'd7:    rom_nresp = 2'd2;
      default: rom_nresp = 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] rom_resp(input logic [3:0] idx, input logic [1:0] ri);
    rom_resp = 8'hFA;
    if (idx == 4'd0 && ri == 2'd1)      rom_resp = 8'hAA;
    else if (idx == 4'd0 && ri == 2'd2) rom_resp = 8'h00;
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    step, step_nxt;
  logic [1:0]    ridx, ridx_nxt;
  logic [3:0]    retry, retry_nxt;
  logic          wheel_nxt;
  logic [7:0]    sh_status, sh_dx, sh_dy, sh_dz;
  logic          ld0, ld1, ld2, ld3;

  logic [3:0]    cur_idx;
  logic          id_slot, resp_ok, resp_last, cnt_clr, fail, byte_bad, counting;

  always_comb begin
    cur_idx   = rom_idx(step);
    id_slot   = (cur_idx == 4'd7) && (ridx == 2'd1);
    resp_last = (ridx == rom_nresp(cur_idx) - 2'd1);
    byte_bad  = (BYTE_ERROR_CODE != 2'b00);
    counting  = (state == S_INIT_WAIT) || (state == S_WAIT_SENT) || (state == S_WAIT_RESP);

    state_nxt = state;
    step_nxt  = step;
    ridx_nxt  = ridx;
    retry_nxt = retry;
    wheel_nxt = WHEEL_PRESENT;
    resp_ok   = 1'b0;
    cnt_clr   = 1'b0;
    fail      = 1'b0;
    ld0       = 1'b0;
    ld1       = 1'b0;
    ld2       = 1'b0;
    ld3       = 1'b0;

    case (state)
      S_INIT_WAIT: if (cnt == INIT_LIM) state_nxt = S_SEND;
      S_SEND:      state_nxt = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_nxt = S_WAIT_RESP;
          ridx_nxt  = 2'd0;
        end else if (cnt == RESP_LIM) begin
          fail = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (BYTE_READY) begin
          if (byte_bad) begin
            fail = 1'b1;
          end else if (id_slot) begin
            if (BYTE_READ == 8'h03) begin
              wheel_nxt = 1'b1;
              resp_ok   = 1'b1;
            end else if (BYTE_READ == 8'h00) begin
              resp_ok = 1'b1;
            end else begin
              fail = 1'b1;
            end
          end else if (BYTE_READ == rom_resp(cur_idx, ridx)) begin
            resp_ok = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (cnt == RESP_LIM) begin
          fail = 1'b1;
        end

        if (resp_ok) begin
          // Each accepted byte restarts the per-response timeout.
          cnt_clr = 1'b1;
          if (!resp_last) begin
            ridx_nxt = ridx + 2'd1;
          end else if (step == LAST_STEP) begin
            state_nxt = S_B0;
            retry_nxt = 4'd0;
          end else begin
            step_nxt  = step + 4'd1;
            state_nxt = S_SEND;
          end
        end
      end
      S_B0: begin
        if (BYTE_READY && !byte_bad && BYTE_READ[3]) begin
          ld0       = 1'b1;
          state_nxt = S_B1;
        end
      end
      S_B1: begin
        if (BYTE_READY) begin
          if (byte_bad) state_nxt = S_B0;
          else begin
            ld1       = 1'b1;
            state_nxt = S_B2;
          end
        end
      end
      S_B2: begin
        if (BYTE_READY) begin
          if (byte_bad) state_nxt = S_B0;
          else begin
            ld2       = 1'b1;
            state_nxt = WHEEL_PRESENT ? S_B3 : S_EMIT;
          end
        end
      end
      S_B3: begin
        if (BYTE_READY) begin
          if (byte_bad) state_nxt = S_B0;
          else begin
            ld3       = 1'b1;
            state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT:  state_nxt = S_B0;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_INIT_WAIT;
    endcase

    if (fail) begin
      step_nxt  = 4'd0;
      ridx_nxt  = 2'd0;
      wheel_nxt = 1'b0;
      retry_nxt = retry + 4'd1;
      state_nxt = ({1'b0, retry} + 5'd1 == RETRY_LIM) ? S_FAULT : S_INIT_WAIT;
    end

    if (state_nxt != state || cnt_clr || !counting) cnt_nxt = '0;
    else                                            cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_INIT_WAIT;
      cnt            <= '0;
      step           <= 4'd0;
      ridx           <= 2'd0;
      retry          <= 4'd0;
      sh_status      <= 8'h00;
      sh_dx          <= 8'h00;
      sh_dy          <= 8'h00;
      sh_dz          <= 8'h00;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      MOUSE_DZ       <= 8'h00;
      WHEEL_PRESENT  <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      INIT_DONE      <= 1'b0;
      INIT_FAIL      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      step          <= step_nxt;
      ridx          <= ridx_nxt;
      retry         <= retry_nxt;
      WHEEL_PRESENT <= wheel_nxt;

      if (ld0) sh_status <= BYTE_READ;
      if (ld1) sh_dx     <= BYTE_READ;
      if (ld2) sh_dy     <= BYTE_READ;
      if (ld3) sh_dz     <= {{4{BYTE_READ[3]}}, BYTE_READ[3:0]};

      // Control outputs follow the next state so they line up with the state they describe.
      SEND_BYTE <= (state_nxt == S_SEND);
      if (state_nxt == S_SEND) BYTE_TO_SEND <= rom_cmd(rom_idx(step_nxt));
      READ_ENABLE <= (state_nxt == S_WAIT_RESP) || (state_nxt == S_B0) || (state_nxt == S_B1) ||
                     (state_nxt == S_B2) || (state_nxt == S_B3) || (state_nxt == S_EMIT);
      INIT_DONE   <= (state_nxt == S_B0) || (state_nxt == S_B1) || (state_nxt == S_B2) ||
                     (state_nxt == S_B3) || (state_nxt == S_EMIT);
      INIT_FAIL   <= (state_nxt == S_FAULT);

      SEND_INTERRUPT <= (state == S_EMIT);
      if (state == S_EMIT) begin
        MOUSE_STATUS <= sh_status;
        MOUSE_DX     <= sh_dx;
        MOUSE_DY     <= sh_dy;
        MOUSE_DZ     <= WHEEL_PRESENT ? sh_dz : 8'h00;
      end
    end
  end

  assign CURR_STATE = state;

endmodule
